// File: rtl/sico_play_scheduler.sv
// sico_play_scheduler: shares one player output bus between N_CH timestamped
// sample sources. Each channel holds one pending sample; a sample is released
// onto val_o once the internal timebase reaches its deadline, with round-robin
// arbitration between channels that are due in the same cycle.
// Optional build macro SICO_SCHED_LATE_STAT_EN adds lateness statistics
// outputs (late_cnt_o, max_late_o).
module sico_play_scheduler #(
   parameter int               N_CH    = 4,
   parameter int               WIDTH   = 8,
   parameter int               TW      = 16,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic [N_CH-1:0]           req_valid_i,
   output logic [N_CH-1:0]           req_ready_o,
   input  logic [N_CH*WIDTH-1:0]     req_val_i,
   input  logic [N_CH*TW-1:0]        req_deadline_i,
   output logic [WIDTH-1:0]          val_o,
   output logic                      upd_o,
   output logic [$clog2(N_CH)-1:0]   upd_ch_o,
   output logic [TW-1:0]             now_o,
   output logic [1:0]                state_o
`ifdef SICO_SCHED_LATE_STAT_EN
   ,
   output logic [15:0]               late_cnt_o,
   output logic [TW-1:0]             max_late_o
`endif
);

   localparam int CW  = $clog2(N_CH);
   localparam int CW1 = CW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] slot_val [N_CH];
   logic [TW-1:0]    slot_dl  [N_CH];
   logic [N_CH-1:0]  full;

   logic [TW-1:0]    age [N_CH];
   logic [N_CH-1:0]  due;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  accept;
   logic             gnt_valid;
   logic [CW-1:0]    gnt_idx;
   logic [CW1-1:0]   pos;
   logic [CW-1:0]    rr_ptr;

   // Wrap-aware due test: a slot is due when now - deadline lands in the lower half of the timebase range
   always_comb begin
      due = '0;
      for (int i = 0; i < N_CH; i++) begin
         age[i] = now_o - slot_dl[i];
         due[i] = full[i] && !age[i][TW-1];
      end
   end

   // Round-robin search over due slots starting at the pointer; only one grant per cycle
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      grant     = '0;
      pos       = '0;
      if (state != ST_IDLE) begin
         for (int k = 0; k < N_CH; k++) begin
            pos = {1'b0, rr_ptr} + CW1'(k);
            if (pos >= CW1'(N_CH)) pos = pos - CW1'(N_CH);
            if (!gnt_valid && due[pos[CW-1:0]]) begin
               gnt_valid = 1'b1;
               gnt_idx   = pos[CW-1:0];
            end
         end
         if (gnt_valid) grant[gnt_idx] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Next-state logic: drain ends once no slot remains full after this edge's grant
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start_i) state_next = ST_RUN;
         ST_RUN:   if (stop_i)  state_next = ST_DRAIN;
         ST_DRAIN: if ((full & ~grant) == '0) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State-decoded outputs: a slot may accept when empty or being granted this cycle
   always_comb begin
      state_o     = state;
      req_ready_o = '0;
      if (state == ST_RUN) req_ready_o = ~full | grant;
      accept      = req_valid_i & req_ready_o;
   end

   // Slot storage: a fresh load takes priority over clearing the granted entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full <= '0;
         for (int i = 0; i < N_CH; i++) begin
            slot_val[i] <= '0;
            slot_dl[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (accept[i]) begin
               full[i]     <= 1'b1;
               slot_val[i] <= req_val_i[i*WIDTH +: WIDTH];
               slot_dl[i]  <= req_deadline_i[i*TW +: TW];
            end else if (grant[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   // Output register and round-robin pointer advance on each grant
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         val_o    <= RST_VAL;
         upd_o    <= 1'b0;
         upd_ch_o <= '0;
         rr_ptr   <= '0;
      end else begin
         upd_o <= gnt_valid;
         if (gnt_valid) begin
            val_o    <= slot_val[gnt_idx];
            upd_ch_o <= gnt_idx;
            rr_ptr   <= (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
         end
      end
   end

   // Timebase: frozen at zero in IDLE, counts in RUN/DRAIN, cleared when drain completes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         now_o <= '0;
      end else if (state == ST_IDLE || state_next == ST_IDLE) begin
         now_o <= '0;
      end else begin
         now_o <= now_o + TW'(1);
      end
   end

`ifdef SICO_SCHED_LATE_STAT_EN
   // Lateness statistics, restarted on every IDLE->RUN transition
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         late_cnt_o <= '0;
         max_late_o <= '0;
      end else if (state == ST_IDLE && state_next == ST_RUN) begin
         late_cnt_o <= '0;
         max_late_o <= '0;
      end else if (gnt_valid && age[gnt_idx] != '0) begin
         if (late_cnt_o != 16'hFFFF) late_cnt_o <= late_cnt_o + 16'd1;
         if (age[gnt_idx] > max_late_o) max_late_o <= age[gnt_idx];
      end
   end
`endif

endmodule
